// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth multiplier among NREQ clients.
// Optional RUN-state watchdog enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mul_go,
    output logic [WIDTH-1:0]        mul_sw,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("booth_mult_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_GAP, S_LOAD_B, S_RUN, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     last_q, last_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]     rsp_product_q, rsp_product_d;
    logic              busy_q, busy_d, mul_go_q, mul_go_d;
    logic [WIDTH-1:0]  mul_sw_q, mul_sw_d;
    logic [LW:0]       pick;
    logic [WIDTH-1:0]  sel_a, sel_b;

    // First set request bit after 'last', wrapping; MSB flags a hit.
    function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] r, input logic [LW-1:0] last);
        logic [LW:0]  res;
        int unsigned  cand;
        res = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last) + k) % NREQ;
            if (!res[LW] && r[cand[LW-1:0]]) res = {1'b1, cand[LW-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        pick  = rr_pick(req, last_q);
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[LW-1:0] == LW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        gnt_d         = gnt_q;
        rsp_product_d = rsp_product_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick[LW]) begin
                    state_d = S_LOAD_A;
                    last_d  = pick[LW-1:0];
                    op_a_d  = sel_a;
                    op_b_d  = sel_b;
                    gnt_d   = NREQ'(1) << pick[LW-1:0];
                end
            end
            S_LOAD_A: state_d = S_GAP;
            S_GAP:    state_d = S_LOAD_B;
            S_LOAD_B: begin
                state_d = S_RUN;
`ifdef BOOTH_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_RUN: begin
                if (mul_done) begin
                    state_d       = S_RESP;
                    rsp_product_d = mul_product;
`ifdef BOOTH_ARB_TIMEOUT_EN
                    err_d         = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d       = S_RESP;
                    rsp_product_d = '0;
                    err_d         = 1'b1;
                end else begin
                    cnt_d         = cnt_q + CW'(1);
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Registered outputs are decoded from the upcoming state.
        busy_d      = (state_d != S_IDLE);
        mul_go_d    = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        rsp_valid_d = (state_d == S_RESP) ? gnt_d : '0;
        case (state_d)
            S_LOAD_A, S_GAP: mul_sw_d = op_a_d;
            S_LOAD_B, S_RUN: mul_sw_d = op_b_d;
            default:         mul_sw_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            last_q        <= LW'(NREQ - 1);
            op_a_q        <= '0;
            op_b_q        <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            busy_q        <= 1'b0;
            mul_go_q      <= 1'b0;
            mul_sw_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            busy_q        <= busy_d;
            mul_go_q      <= mul_go_d;
            mul_sw_q      <= mul_sw_d;
        end
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign busy        = busy_q;
    assign mul_go      = mul_go_q;
    assign mul_sw      = mul_sw_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter with a behavioural multiplier model.
module tb_booth_mult_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned PW   = 16;
    localparam int          TO   = 64;

    logic                  clock, reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*W-1:0]     req_a, req_b;
    logic [NREQ-1:0]       gnt, rsp_valid;
    logic [PW-1:0]         rsp_product;
    logic                  rsp_err, busy, mul_go, mul_done;
    logic [W-1:0]          mul_sw;
    logic [PW-1:0]         mul_product;

    booth_mult_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .busy(busy), .mul_go(mul_go), .mul_sw(mul_sw), .mul_done(mul_done),
        .mul_product(mul_product)
    );

    typedef struct {
        int          idx;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         go2_cyc = 0;
    int         cur_delay = 1;
    int         force_delay = 0;
    bit         suppress_done = 0;
    int         phase = 0;
    int         rr_last = NREQ - 1;
    logic [7:0] a_op[NREQ];
    logic [7:0] b_op[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 16'(sa * sb);
    endfunction

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Multiplier model: watches the go/sw load sequence and returns a product after a delay.
    initial begin
        int         cd;
        logic [7:0] cap_a, cap_b;
        logic [15:0] pend;
        mul_done = 0; mul_product = '0; cd = -1; cap_a = '0; cap_b = '0; pend = '0;
        forever begin
            @(posedge clock); #1;
            mul_done = 0;
            if (cd > 0) cd--;
            if (cd == 0) begin
                mul_done = 1; mul_product = pend; cd = -1;
            end
            if (!reset) phase = 0;
            else case (phase)
                0: if (mul_go) begin
                    if (exp_q.size() == 0) check("unexpected_go", 64'(mul_sw), 64'hDEAD);
                    else check("load_a", {mul_go, mul_sw}, {1'b1, exp_q[0].a});
                    cap_a = mul_sw; phase = 1;
                end
                1: begin
                    if (exp_q.size() != 0) check("gap", {mul_go, mul_sw}, {1'b0, exp_q[0].a});
                    phase = 2;
                end
                2: begin
                    if (exp_q.size() != 0) check("load_b", {mul_go, mul_sw}, {1'b1, exp_q[0].b});
                    cap_b = mul_sw; pend = smul(cap_a, cap_b); go2_cyc = cyc;
                    if (!suppress_done) begin
                        cur_delay = (force_delay != 0) ? force_delay : int'($urandom_range(1, 8));
                        cd = cur_delay;
                    end
                    phase = 3;
                end
                default: if (!busy) phase = 0;
            endcase
        end
    end

    // Monitor: grant invariants every cycle; pops the scoreboard on each response.
    initial forever begin
        exp_t e;
        int   lat;
        @(negedge clock);
        if ($countones(gnt) > 1 || busy !== (gnt != '0)) check("gnt_busy", {busy, gnt}, {(gnt != '0), 4'b0001});
        if (rsp_valid != '0) begin
            if (exp_q.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'h0);
            else begin
                e = exp_q.pop_front();
                lat = cyc - go2_cyc;
                check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.idx));
                check("rsp_gnt", 64'(gnt), 64'(rsp_valid));
                check("rsp_product", 64'(rsp_product), 64'(e.prod));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_latency", 64'(lat), 64'(e.err ? TO + 1 : cur_delay + 1));
            end
        end
    end

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_op[i];
            req_b[i*W +: W] = b_op[i];
        end
    endtask

    // Reference arbitration: serve 'total' grants round-robin over the mask.
    task automatic push_expected(input logic [NREQ-1:0] mask, input int total, input bit tmo);
        exp_t e;
        int   c;
        for (int t = 0; t < total; t++) begin
            c = rr_last;
            for (int k = 1; k <= NREQ; k++) begin
                c = (rr_last + k) % NREQ;
                if (mask[c]) break;
            end
            e.idx = c; e.a = a_op[c]; e.b = b_op[c];
            e.prod = tmo ? 16'h0 : smul(a_op[c], b_op[c]);
            e.err  = tmo;
            exp_q.push_back(e);
            rr_last = c;
        end
    endtask

    task automatic serve(input logic [NREQ-1:0] mask, input int total, input bit hold, input bit scramble);
        int got = 0;
        int budget = 200 * total;
        while (got < total && budget > 0) begin
            @(negedge clock);
            budget--;
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    got++;
                    if (!hold) req[i] = 1'b0;
                end else if (gnt[i] && scramble) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end
            end
        end
        if (hold) req = req & ~mask;
        check("serve_count", 64'(got), 64'(total));
    endtask

    task automatic do_reset_flush();
        reset = 0; req = '0;
        exp_q.delete();
        rr_last = NREQ - 1;
    endtask

    initial begin
        logic [NREQ-1:0] m;
        int              wait_n;
        reset = 0; req = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin a_op[i] = 8'(i + 1); b_op[i] = 8'(8'hF0 + i); end
        load_ops();
        repeat (2) @(negedge clock);

        // Reset with all requesters asking; requester 0 must win first.
        push_expected(4'b1111, 4, 0);
        req = 4'b1111;
        repeat (3) @(negedge clock);
        check("reset_outputs", {gnt, rsp_valid, rsp_product, rsp_err, busy, mul_go, mul_sw}, 64'h0);
        reset = 1;
        @(negedge clock);
        check("first_gnt", 64'(gnt), 64'(4'b0001));
        serve(4'b1111, 4, 0, 0);

        // Single request with a fixed 6-cycle multiplier.
        force_delay = 6;
        a_op[1] = 8'h02; b_op[1] = 8'h06; load_ops();
        push_expected(4'b0010, 1, 0);
        check("exp_0c", 64'(exp_q[0].prod), 64'h000C);
        req = 4'b0010;
        serve(4'b0010, 1, 0, 0);
        @(negedge clock);
        check("rsp_pulse_len", 64'(rsp_valid), 64'h0);

        // Signed product.
        a_op[3] = 8'hFD; b_op[3] = 8'h05; load_ops();
        push_expected(4'b1000, 1, 0);
        req = 4'b1000;
        serve(4'b1000, 1, 0, 0);
        force_delay = 0;

        // Two requesters held high alternate.
        a_op[0] = 8'h81; b_op[0] = 8'h7F; a_op[2] = 8'h10; b_op[2] = 8'hF8; load_ops();
        push_expected(4'b0101, 4, 0);
        req = 4'b0101;
        serve(4'b0101, 4, 1, 0);

        // Random contention rounds with operand scrambling after grant.
        for (int r = 0; r < 25; r++) begin
            m = NREQ'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin a_op[i] = 8'($urandom); b_op[i] = 8'($urandom); end
            load_ops();
            push_expected(m, $countones(m), 0);
            req = m;
            serve(m, $countones(m), 0, 1);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Reset during RUN discards the transaction.
        force_delay = 8;
        a_op[1] = 8'h33; b_op[1] = 8'h44; load_ops();
        push_expected(4'b0010, 1, 0);
        req = 4'b0010;
        wait_n = 0;
        while (phase != 3 && wait_n < 50) begin @(negedge clock); wait_n++; end
        check("reach_run", 64'(phase), 64'd3);
        @(negedge clock);
        do_reset_flush();
        #1;
        check("async_reset", {gnt, rsp_valid, rsp_product, busy, mul_go, mul_sw}, 64'h0);
        repeat (3) @(negedge clock);
        reset = 1;
        repeat (12) @(negedge clock);
        check("idle_after_reset", {busy, rsp_valid}, 64'h0);
        force_delay = 0;
        a_op[0] = 8'h05; b_op[0] = 8'hFB; a_op[2] = 8'h7F; b_op[2] = 8'h7F; load_ops();
        push_expected(4'b0101, 2, 0);
        check("exp_first_after_reset", 64'(exp_q[0].idx), 64'd0);
        req = 4'b0101;
        serve(4'b0101, 2, 0, 0);

        // Multiplier never completes.
        suppress_done = 1;
        a_op[1] = 8'h09; b_op[1] = 8'h09; load_ops();
`ifdef BOOTH_ARB_TIMEOUT_EN
        push_expected(4'b0010, 1, 1);
        req = 4'b0010;
        serve(4'b0010, 1, 0, 0);
`else
        push_expected(4'b0010, 1, 0);
        req = 4'b0010;
        repeat (150) @(negedge clock);
        check("busy_hang", {busy, rsp_valid}, {1'b1, 4'b0000});
        do_reset_flush();
        repeat (2) @(negedge clock);
        reset = 1;
`endif
        suppress_done = 0;
        repeat (4) @(negedge clock);
        check("final_idle", 64'(busy), 64'h0);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
